dmem_arbiter: RTL and testbench

Shares the single-port 128-word data memory between the single-cycle MIPS core and a secondary host requester (debug/DMA loader) doing burst transfers. The core's accesses go straight through, with no added cycles, while the arbiter is idle. A host burst takes the memory for consecutive cycles and stalls the core for any access it attempts during the burst. An optional fairness counter stops the core from starving the host.

---
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, host-burst and memory-pin signals seen by the data-memory arbiter.
// slave = arbiter side, master = requesters plus the memory macro.
interface dmem_arbiter_if #(
   parameter int unsigned AW    = 7,
   parameter int unsigned DW    = 32,
   parameter int unsigned LEN_W = 4
) ();
   logic             cpu_en;
   logic             cpu_wr;
   logic [AW-1:0]    cpu_addr;
   logic [DW-1:0]    cpu_wdata;
   logic [DW-1:0]    cpu_rdata;
   logic             cpu_stall;

   logic             host_req;
   logic             host_wr;
   logic [AW-1:0]    host_addr;
   logic [LEN_W-1:0] host_len;
   logic [DW-1:0]    host_wdata;
   logic             host_ack;
   logic [DW-1:0]    host_rdata;
   logic             host_rvalid;
   logic             host_done;

   logic             mem_CEN;
   logic             mem_WEN;
   logic             mem_OEN;
   logic [AW-1:0]    mem_A;
   logic [DW-1:0]    mem_D;
   logic [DW-1:0]    mem_Q;

   modport slave (
      input  cpu_en, cpu_wr, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  host_req, host_wr, host_addr, host_len, host_wdata,
      output host_ack, host_rdata, host_rvalid, host_done,
      output mem_CEN, mem_WEN, mem_OEN, mem_A, mem_D,
      input  mem_Q
   );

   modport master (
      output cpu_en, cpu_wr, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output host_req, host_wr, host_addr, host_len, host_wdata,
      input  host_ack, host_rdata, host_rvalid, host_done,
      input  mem_CEN, mem_WEN, mem_OEN, mem_A, mem_D,
      output mem_Q
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (zero-latency pass-through) and host bursts.
// Define DMEM_ARB_FAIR_EN to add the wait counter that forces a starved host in after MAX_WAIT cycles.
module dmem_arbiter #(
   parameter int unsigned AW       = 7,
   parameter int unsigned DW       = 32,
   parameter int unsigned LEN_W    = 4,
   parameter int unsigned MAX_WAIT = 4
) (
   input logic           clk,
   input logic           rst_n,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             wr_q, wr_d;
   logic [DW-1:0]    rdata_q, rdata_d;
   logic             rvalid_q, rvalid_d;
   logic             done_q, done_d;
   logic             grant;
   logic             fair_hit;

`ifdef DMEM_ARB_FAIR_EN
   localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
   logic [WaitW-1:0] wait_q, wait_d;

   assign fair_hit = (wait_q == WaitW'(MAX_WAIT));

   // Counts only IDLE cycles in which the core actually blocks a pending host request.
   always_comb begin
      wait_d = wait_q;
      if (grant || !bus.host_req) begin
         wait_d = '0;
      end else if (state_q == StIdle && bus.cpu_en && !fair_hit) begin
         wait_d = wait_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wait_q <= '0;
      else        wait_q <= wait_d;
   end
`else
   assign fair_hit = 1'b0;
`endif

   assign grant = (state_q == StIdle) && bus.host_req && (!bus.cpu_en || fair_hit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         cnt_q    <= '0;
         wr_q     <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         wr_q     <= wr_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      wr_d     = wr_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      done_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (grant) begin
               state_d = StBurst;
               addr_d  = bus.host_addr;
               cnt_d   = bus.host_len;
               wr_d    = bus.host_wr;
            end
         end
         StBurst: begin
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
            if (!wr_q) begin
               rvalid_d = 1'b1;
               rdata_d  = bus.mem_Q;
            end
            if (cnt_q == '0) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.cpu_stall = 1'b0;
      bus.host_ack  = 1'b0;
      bus.mem_CEN   = !bus.cpu_en;
      bus.mem_WEN   = !(bus.cpu_en && bus.cpu_wr);
      bus.mem_OEN   = !(bus.cpu_en && !bus.cpu_wr);
      bus.mem_A     = bus.cpu_en ? bus.cpu_addr : '0;
      bus.mem_D     = bus.cpu_en ? bus.cpu_wdata : '0;
      unique case (state_q)
         StIdle: ;
         StBurst: begin
            bus.cpu_stall = bus.cpu_en;
            bus.host_ack  = 1'b1;
            bus.mem_CEN   = 1'b0;
            bus.mem_WEN   = !wr_q;
            bus.mem_OEN   = wr_q;
            bus.mem_A     = addr_q;
            bus.mem_D     = bus.host_wdata;
         end
         default: ;
      endcase
   end

   assign bus.cpu_rdata   = bus.mem_Q;
   assign bus.host_rdata  = rdata_q;
   assign bus.host_rvalid = rvalid_q;
   assign bus.host_done   = done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus random bench for dmem_arbiter, checked against a beat-queue reference model.
module tb_dmem_arbiter;

   localparam int unsigned AW       = 7;
   localparam int unsigned DW       = 32;
   localparam int unsigned LEN_W    = 4;
   localparam int unsigned MAX_WAIT = 4;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          wr;
      logic          last;
   } beat_t;

   logic clk;
   logic rst_n;

   dmem_arbiter_if #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) bus ();

   dmem_arbiter #(.AW(AW), .DW(DW), .LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory macro: write on the clock edge, combinational read.
   logic [DW-1:0] mem [128];
   always @(posedge clk) begin
      if (!bus.mem_CEN && !bus.mem_WEN) mem[bus.mem_A] <= bus.mem_D;
   end
   assign bus.mem_Q = (!bus.mem_CEN && !bus.mem_OEN) ? mem[bus.mem_A] : '0;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   beat_t         beat_q[$];
   logic [DW-1:0] exp_mem [128];
   bit            known   [128];
   int            wait_cnt;
   bit            prev_rd, prev_last, prev_known;
   logic [DW-1:0] prev_data;

   // Observations from the latest tick, for directed checks
   logic          obs_ack, obs_done, obs_rvalid, obs_stall, obs_cen, obs_wen, obs_oen;
   logic [AW-1:0] obs_a;
   logic [DW-1:0] obs_rdata, obs_cpu_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      beat_q.delete();
      wait_cnt  = 0;
      prev_rd   = 0;
      prev_last = 0;
   endtask

   // Entered at posedge+1 with inputs set; checks at the negedge, then advances to next posedge+1.
   task automatic tick();
      beat_t b;
      beat_t nb;
      bit    have;
      bit    fair;
      #4;
      have = (beat_q.size() != 0);
      b    = have ? beat_q[0] : '0;
      obs_ack = bus.host_ack;  obs_done = bus.host_done;  obs_rvalid = bus.host_rvalid;
      obs_stall = bus.cpu_stall;  obs_cen = bus.mem_CEN;  obs_wen = bus.mem_WEN;
      obs_oen = bus.mem_OEN;  obs_a = bus.mem_A;  obs_rdata = bus.host_rdata;
      obs_cpu_rdata = bus.cpu_rdata;

      chk("host_rvalid", 32'(bus.host_rvalid), 32'(prev_rd));
      chk("host_done", 32'(bus.host_done), 32'(prev_last));
      if (prev_rd && prev_known) chk("host_rdata", bus.host_rdata, prev_data);
      if (have) begin
         chk("burst_ack", 32'(bus.host_ack), 32'd1);
         chk("burst_A", 32'(bus.mem_A), 32'(b.addr));
         chk("burst_CEN", 32'(bus.mem_CEN), 32'd0);
         chk("burst_WEN", 32'(bus.mem_WEN), 32'(!b.wr));
         chk("burst_OEN", 32'(bus.mem_OEN), 32'(b.wr));
         chk("burst_stall", 32'(bus.cpu_stall), 32'(bus.cpu_en));
      end else begin
         chk("idle_ack", 32'(bus.host_ack), 32'd0);
         chk("idle_stall", 32'(bus.cpu_stall), 32'd0);
         chk("idle_CEN", 32'(bus.mem_CEN), 32'(!bus.cpu_en));
         chk("idle_WEN", 32'(bus.mem_WEN), 32'(!(bus.cpu_en && bus.cpu_wr)));
         chk("idle_OEN", 32'(bus.mem_OEN), 32'(!(bus.cpu_en && !bus.cpu_wr)));
         chk("idle_A", 32'(bus.mem_A), bus.cpu_en ? 32'(bus.cpu_addr) : 32'd0);
         if (bus.cpu_en && !bus.cpu_wr && known[bus.cpu_addr])
            chk("cpu_rdata", bus.cpu_rdata, exp_mem[bus.cpu_addr]);
      end

      if (rst_n) begin
         prev_rd   = have && !b.wr;
         prev_last = have && b.last;
         if (have && !b.wr) begin
            prev_known = known[b.addr];
            prev_data  = exp_mem[b.addr];
         end
         if (have && b.wr) begin
            exp_mem[b.addr] = bus.host_wdata;
            known[b.addr]   = 1;
         end
         if (!have && bus.cpu_en && bus.cpu_wr) begin
            exp_mem[bus.cpu_addr] = bus.cpu_wdata;
            known[bus.cpu_addr]   = 1;
         end
`ifdef DMEM_ARB_FAIR_EN
         fair = (wait_cnt == int'(MAX_WAIT));
`else
         fair = 0;
`endif
         if (have) begin
            void'(beat_q.pop_front());
            if (!bus.host_req) wait_cnt = 0;
         end else if (bus.host_req && (!bus.cpu_en || fair)) begin
            for (int k = 0; k <= int'(bus.host_len); k++) begin
               nb.addr = AW'(int'(bus.host_addr) + k);
               nb.wr   = bus.host_wr;
               nb.last = (k == int'(bus.host_len));
               beat_q.push_back(nb);
            end
            wait_cnt = 0;
         end else if (bus.host_req) begin
            if (wait_cnt < int'(MAX_WAIT)) wait_cnt++;
         end else begin
            wait_cnt = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [DW-1:0] wd [3];
      int            n;
      int            stall_cnt;
      int            exp_wait;

      for (int i = 0; i < 128; i++) known[i] = 0;
      model_reset();
      rst_n = 1'b0;
      bus.cpu_en = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.host_req = 0; bus.host_wr = 0; bus.host_addr = '0; bus.host_len = '0;
      bus.host_wdata = '0;

      // Reset values
      #3;
      chk("rst_CEN", 32'(bus.mem_CEN), 32'd1);
      chk("rst_WEN", 32'(bus.mem_WEN), 32'd1);
      chk("rst_OEN", 32'(bus.mem_OEN), 32'd1);
      chk("rst_A", 32'(bus.mem_A), 32'd0);
      chk("rst_rvalid", 32'(bus.host_rvalid), 32'd0);
      chk("rst_done", 32'(bus.host_done), 32'd0);
      chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Core write then read of 0x05
      bus.cpu_en = 1; bus.cpu_wr = 1; bus.cpu_addr = 7'h05; bus.cpu_wdata = 32'hDEADBEEF;
      tick();
      chk("cpu_wr_CEN", 32'(obs_cen), 32'd0);
      chk("cpu_wr_WEN", 32'(obs_wen), 32'd0);
      bus.cpu_wr = 0;
      tick();
      chk("cpu_rd_OEN", 32'(obs_oen), 32'd0);
      chk("cpu_rd_data", obs_cpu_rdata, 32'hDEADBEEF);
      chk("cpu_rd_stall", 32'(obs_stall), 32'd0);

      // Host write burst wrapping 0x7E..0x00
      bus.cpu_en = 0;
      bus.host_req = 1; bus.host_wr = 1; bus.host_addr = 7'h7E; bus.host_len = 4'd2;
      tick();
      bus.host_req = 0;
      for (int i = 0; i < 3; i++) begin
         wd[i] = $urandom;
         bus.host_wdata = wd[i];
         tick();
         chk("wrap_ack", 32'(obs_ack), 32'd1);
         chk("wrap_A", 32'(obs_a), 32'(AW'(7'h7E + i)));
      end
      tick();
      chk("wrap_done", 32'(obs_done), 32'd1);
      bus.cpu_en = 1; bus.cpu_wr = 0;
      for (int i = 0; i < 3; i++) begin
         bus.cpu_addr = AW'(7'h7E + i);
         tick();
         chk("wrap_readback", obs_cpu_rdata, wd[i]);
      end

      // Fill the whole memory with eight 16-beat host write bursts
      bus.cpu_en = 0;
      for (int j = 0; j < 8; j++) begin
         bus.host_req = 1; bus.host_wr = 1; bus.host_addr = AW'(j * 16); bus.host_len = 4'd15;
         tick();
         bus.host_req = 0;
         for (int i = 0; i < 16; i++) begin
            bus.host_wdata = $urandom;
            tick();
         end
      end
      tick();

      // 4-beat read burst with the core trying to access throughout
      bus.host_req = 1; bus.host_wr = 0; bus.host_addr = 7'h20; bus.host_len = 4'd3;
      tick();
      bus.host_req = 0; bus.cpu_en = 1; bus.cpu_wr = 0; bus.cpu_addr = 7'h11;
      stall_cnt = 0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         stall_cnt += int'(obs_stall);
         chk("rd_rvalid", 32'(obs_rvalid), 32'(k >= 2 && k <= 5));
         if (k >= 2 && k <= 5) chk("rd_data", obs_rdata, exp_mem[7'h20 + k - 2]);
      end
      chk("rd_stall_cnt", 32'(stall_cnt), 32'd4);

      // Host held off by a continuously busy core
      bus.cpu_en = 1; bus.cpu_wr = 0; bus.cpu_addr = 7'h10;
      bus.host_req = 1; bus.host_wr = 0; bus.host_addr = 7'h03; bus.host_len = 4'd0;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (obs_ack) break;
         n++;
      end
`ifdef DMEM_ARB_FAIR_EN
      exp_wait = int'(MAX_WAIT) + 1;
`else
      exp_wait = 12;
`endif
      chk("fair_wait", 32'(n), 32'(exp_wait));
      bus.cpu_en = 0;
      tick();
      bus.host_req = 0;
      tick();
      chk("late_ack", 32'(obs_ack), 32'd1);
      tick();

      // Reset during beat 2 of a 4-beat burst
      bus.host_req = 1; bus.host_wr = 0; bus.host_addr = 7'h40; bus.host_len = 4'd3;
      tick();
      bus.host_req = 0;
      tick();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_ack", 32'(bus.host_ack), 32'd0);
      chk("midrst_CEN", 32'(bus.mem_CEN), 32'd1);
      chk("midrst_done", 32'(bus.host_done), 32'd0);
      chk("midrst_rvalid", 32'(bus.host_rvalid), 32'd0);
      tick();
      rst_n = 1'b1;
      bus.host_req = 1; bus.host_addr = 7'h50; bus.host_len = 4'd1;
      tick();
      chk("postrst_done", 32'(obs_done), 32'd0);
      bus.host_req = 0;
      tick();
      chk("postrst_ack", 32'(obs_ack), 32'd1);
      chk("postrst_A", 32'(obs_a), 32'h50);
      tick();
      tick();

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         bus.cpu_en     = ($urandom_range(0, 1) == 1);
         bus.cpu_wr     = ($urandom_range(0, 2) == 0);
         bus.cpu_addr   = AW'($urandom);
         bus.cpu_wdata  = $urandom;
         bus.host_req   = ($urandom_range(0, 3) == 0);
         bus.host_wr    = ($urandom_range(0, 1) == 1);
         bus.host_addr  = AW'($urandom);
         bus.host_len   = LEN_W'($urandom);
         bus.host_wdata = $urandom;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
